// File: rtl/rvb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvb_pkg
// Description : Shared constants and types for the bitmanip arbiter slice.
//               Defines the compressed instruction-bit vector carried to the
//               shared unit and a helper for round-robin pointer widths.
// Revision    : 1.0 - initial release
// ============================================================================
package rvb_pkg;

  // Compressed instruction vector: {b30,b27,b26,b25,b14,b13,b12,b5,b3}
  localparam int INSN_W   = 9;
  localparam int INSN_B30 = 8;
  localparam int INSN_B27 = 7;
  localparam int INSN_B26 = 6;
  localparam int INSN_B25 = 5;
  localparam int INSN_B14 = 4;
  localparam int INSN_B13 = 3;
  localparam int INSN_B12 = 2;
  localparam int INSN_B5  = 1;
  localparam int INSN_B3  = 0;

  typedef logic [INSN_W-1:0] insn_t;

  // Width of a pointer able to name any of n requesters (at least 1 bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rvb_rr_arb
// Description : Purely combinational round-robin selector. Scans the request
//               vector starting at index ptr and wrapping at N-1, and grants
//               the first requester found. The pointer register lives in the
//               parent so that it only advances on an accepted transfer.
// Ports       : req  [N]      - eligible requesters
//               ptr  [PTR_W]  - highest-priority index this cycle (< N)
//               gnt  [N]      - one-hot grant, zero when req is zero
// Revision    : 1.0 - initial release
// ============================================================================
module rvb_rr_arb
  import rvb_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk N positions from ptr; idx wraps explicitly so N need not be a
  // power of two.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
      idx = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rvb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rvb_arbiter
// Description : Shares one single-cycle bitmanip execution unit between NREQ
//               issue ports. A round-robin grant selects one eligible
//               requester per cycle, its operands are muxed onto the unit,
//               and the unit's result is captured into that requester's own
//               one-deep output buffer, so a stalled consumer only blocks
//               itself.
// Ports       : clock, resetn                 - clock, async active-low reset
//               req_valid/req_ready [NREQ]     - per-requester issue handshake
//               req_rs1/2/3 [NREQ*XLEN]        - flattened operands
//               req_insn [NREQ*9]              - flattened instruction bits
//               rsp_valid/rsp_ready [NREQ]     - per-requester result handshake
//               rsp_rd [NREQ*XLEN]             - flattened buffered results
//               unit_valid/unit_ready          - shared unit input handshake
//               unit_rs1/2/3, unit_insn        - shared unit operands
//               unit_rd_valid, unit_rd         - shared unit result
//               unit_rd_ready                  - always accepting
// Revision    : 1.0 - initial release
// ============================================================================
module rvb_arbiter
  import rvb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*XLEN-1:0]   req_rs1,
  input  logic [NREQ*XLEN-1:0]   req_rs2,
  input  logic [NREQ*XLEN-1:0]   req_rs3,
  input  logic [NREQ*INSN_W-1:0] req_insn,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*XLEN-1:0]   rsp_rd,
  output logic                   unit_valid,
  input  logic                   unit_ready,
  output logic [XLEN-1:0]        unit_rs1,
  output logic [XLEN-1:0]        unit_rs2,
  output logic [XLEN-1:0]        unit_rs3,
  output logic [INSN_W-1:0]      unit_insn,
  input  logic                   unit_rd_valid,
  input  logic [XLEN-1:0]        unit_rd,
  output logic                   unit_rd_ready
);

  localparam int PTR_W = ptr_width(NREQ);

  logic [NREQ-1:0]           buf_full;
  logic [NREQ-1:0][XLEN-1:0] buf_data;
  logic [PTR_W-1:0]          rr_ptr;
  logic [PTR_W-1:0]          rr_ptr_nxt;
  logic [PTR_W-1:0]          gnt_idx;
  logic [NREQ-1:0]           elig;
  logic [NREQ-1:0]           gnt;
  logic                      fire;
  insn_t                     sel_insn;

  // A full buffer may take a new result in the same cycle it is drained.
  // resetn gates eligibility so that grant, unit_valid and req_ready all
  // drop the moment reset asserts, independent of the requesters.
  assign elig = {NREQ{resetn}} & req_valid & (~buf_full | rsp_ready);

  rvb_rr_arb #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // The unit is single-cycle: a transfer completes only when it both takes
  // the operands and presents the result in the same cycle. Otherwise the
  // grant simply persists because nothing it depends on changes.
  assign fire          = unit_ready & unit_rd_valid;
  assign req_ready     = gnt & {NREQ{fire}};
  assign unit_valid    = |gnt;
  assign unit_rd_ready = 1'b1;

  assign rsp_valid = buf_full;
  assign rsp_rd    = buf_data;

  // Operand mux; all-zero when nothing is granted.
  always_comb begin
    unit_rs1 = '0;
    unit_rs2 = '0;
    unit_rs3 = '0;
    sel_insn = '0;
    gnt_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        unit_rs1 = req_rs1[i*XLEN +: XLEN];
        unit_rs2 = req_rs2[i*XLEN +: XLEN];
        unit_rs3 = req_rs3[i*XLEN +: XLEN];
        sel_insn = req_insn[i*INSN_W +: INSN_W];
        gnt_idx  = PTR_W'(i);
      end
    end
  end

  assign unit_insn = sel_insn;

  // Priority moves to the requester just after the one served.
  assign rr_ptr_nxt = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buf_full <= '0;
      buf_data <= '0;
      rr_ptr   <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          // Refill wins over a simultaneous drain: the buffer stays full.
          buf_data[i] <= unit_rd;
          buf_full[i] <= 1'b1;
        end else if (rsp_ready[i]) begin
          buf_full[i] <= 1'b0;
        end
      end
      if (|req_ready) begin
        rr_ptr <= rr_ptr_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/rvb_arbiter.md
# rvb_arbiter

Round-robin arbiter and result buffer that shares one combinational bitmanip execution unit between `NREQ` independent issue ports, for example several harts or a dual-issue front end. Each cycle it grants at most one requester and drives that requester's operands and instruction bits into the shared unit. It captures the unit's result into a per-requester one-deep output buffer. Because each requester has its own buffer, a requester that stalls its output does not block the others.

## Interface
Parameters:
- `XLEN`, 32, operand width; 32 or 64 only.
- `NREQ`, 2, number of requesters; 2..8.

Ports:
- `clock`  in  1  positive-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request valid, per requester.
- `req_ready`  out  NREQ  request accepted, per requester.
- `req_rs1`, `req_rs2`, `req_rs3`  in  NREQ*XLEN  flattened operands; requester i occupies `[i*XLEN +: XLEN]`.
- `req_insn`  in  NREQ*9  flattened instruction bits; per requester `{b30,b27,b26,b25,b14,b13,b12,b5,b3}`, MSB first.
- `rsp_valid`  out  NREQ  result valid, per requester.
- `rsp_ready`  in  NREQ  result accepted, per requester.
- `rsp_rd`  out  NREQ*XLEN  flattened results.
- `unit_valid`  out  1  shared unit input valid.
- `unit_ready`  in  1  shared unit accepts input.
- `unit_rs1`, `unit_rs2`, `unit_rs3`  out  XLEN  shared unit operands.
- `unit_insn`  out  9  shared unit instruction bits.
- `unit_rd_valid`  in  1  shared unit output valid.
- `unit_rd`  in  XLEN  shared unit result.
- `unit_rd_ready`  out  1  shared unit output accept; tied high.

## Operation
- Per-requester output buffer: `buf_full[i]` plus `buf_data[i]`.
- `rsp_valid[i] = buf_full[i]`; `rsp_rd[i] = buf_data[i]`.
- Eligibility: `elig[i] = req_valid[i] && (!buf_full[i] || rsp_ready[i])`. This allows same-cycle drain and refill.
- Grant selection:
  - Round-robin over `elig`, starting at pointer `rr_ptr`.
  - The grant is a one-hot `gnt`, or zero if nothing is eligible.
  - The grant is combinational within the cycle.
- Shared unit drive:
  - `unit_valid = |gnt`.
  - Operands and instruction bits are muxed from the granted requester.
  - When nothing is granted, operands are driven to 0.
- Acceptance:
  - `req_ready[i] = gnt[i] && unit_ready && unit_rd_valid`.
  - The unit is single-cycle: its result is valid in the same cycle as its input.
  - If `unit_rd_valid` is low while `unit_valid` is high, the grant is held, nothing is accepted, and `rr_ptr` does not move.
- On accept by requester g: `buf_data[g] <= unit_rd`; `buf_full[g] <= 1`; `rr_ptr <= (g+1) mod NREQ`.
- On `rsp_valid[i] && rsp_ready[i]` with no refill: `buf_full[i] <= 0`.
- Simultaneous drain and refill of the same buffer: the buffer stays full and takes the new data.
- A requester with a full buffer and a low `rsp_ready` is skipped. The others still progress.
- `rr_ptr` wraps from `NREQ-1` to 0.
- The arbiter does not inspect, modify or width-adjust results; `unit_rd` is stored as-is.

## Timing
- Reset (asynchronous assert, synchronous-to-`clock` deassert expected upstream):
  - `buf_full = 0`, `buf_data = 0`, `rr_ptr = 0`.
  - Hence `rsp_valid = 0`, `rsp_rd = 0`, `req_ready = 0`, `unit_valid = 0`.
- Latency: a request accepted in cycle t gives `rsp_valid` in cycle t+1.
- Throughput: one accepted request per cycle in aggregate; one per cycle per requester while its `rsp_ready` stays high.
- Reset asserted mid-operation: buffered results are discarded and `req_ready` drops immediately, with no partial accept.
- All register updates happen on the `clock` rising edge. There are no combinational paths from `rsp_ready` to `rsp_valid`. `rsp_ready` does feed `req_ready` combinationally.

## Structure
- Package `rvb_pkg`:
  - `INSN_W = 9`.
  - Bit-index constants `INSN_B30 … INSN_B3` for positions 8..0.
  - Typedef `insn_t` (logic [8:0]).
- Sub-module `rvb_rr_arb`:
  - Parameter `N`.
  - Inputs: `req[N]`, `ptr`.
  - Output: one-hot `gnt`.
  - Purely combinational.
  - The pointer register stays in `rvb_arbiter`.
- Top level holds the buffers, muxes and pointer. Target size is about 150–250 lines of RTL.

## Test plan
- XLEN=32, NREQ=2, unit stubbed as single-cycle. Requester 0 sends ANDN (insn `9'b100011110`), rs1=0xF0F0F0F0, rs2=0xFF00FF00 -> `rsp_valid[0]` one cycle later, `rsp_rd[0]` = 0x00F000F0.
- Both requesters valid every cycle, both `rsp_ready` high, `rr_ptr` = 0 -> grants alternate 0,1,0,1. Each requester receives one result every 2 cycles, in order.
- `rsp_ready[0]` held low, requester 0 refires -> its first result stays 0x00F000F0 and `req_ready[0]` stays 0. Requester 1 proceeds: MIN (insn `9'b010110010`), rs1=0xFFFFFFFF, rs2=1 -> 0xFFFFFFFF.
- Same-cycle drain and refill: `buf_full[1]` = 1 with `rsp_ready[1]` = 1, new MAXU rs1=0xFFFFFFFF, rs2=1 -> the buffer stays full and the next cycle shows 0xFFFFFFFF with no bubble.
- `resetn` pulled low mid-stream with both buffers full -> all `rsp_valid` = 0 and `unit_valid` = 0 at once. After release, the first grant goes to requester 0.
- NREQ=3, only requester 2 valid -> grant 2, then `rr_ptr` wraps to 0. `unit_rd_valid` forced low for 2 cycles -> no accept and the pointer is unchanged.
